// File: rtl/vga_sync_decoder_480p_if.sv
// vga_sync_decoder_480p_if: sync inputs and recovered timing outputs of the 480p sync decoder
interface vga_sync_decoder_480p_if;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       pix_valid;
  logic       line_start;
  logic       frame_start;
  logic       locked;
  logic [11:0] h_total;
  logic [11:0] v_total;
  logic       err_timing;
  modport master (
    output hsync, vsync, de,
    input  sx, sy, pix_valid, line_start, frame_start, locked, h_total, v_total, err_timing
  );
  modport slave (
    input  hsync, vsync, de,
    output sx, sy, pix_valid, line_start, frame_start, locked, h_total, v_total, err_timing
  );
endinterface

// File: rtl/vga_sync_decoder_480p.sv
// vga_sync_decoder_480p: recovers pixel coordinates and line/frame timing from VGA syncs and reports lock
module vga_sync_decoder_480p #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 2047
) (
  input  logic                    clk_vga,
  input  logic                    rst_n,
  vga_sync_decoder_480p_if.slave  bus
);
  localparam logic [11:0] HT = 12'(H_TOTAL);
  localparam logic [11:0] HA = 12'(H_ACTIVE);
  localparam logic [11:0] VT = 12'(V_TOTAL);
  localparam logic [11:0] VA = 12'(V_ACTIVE);
  localparam logic [11:0] TO = 12'(TIMEOUT - 1);
  localparam logic [3:0]  LF = 4'(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t      state;
  logic        hs_q, vs_q, de_q, vs_seen, bad_seen;
  logic [11:0] h_cnt, a_cnt, ln_cnt, act_ln;
  logic [3:0]  good_cnt;
  logic        hs_a, vs_a, de_r, line_bad, frame_good, time_out, first_row;
  logic [11:0] h_len, ln_eff;
  always_comb begin
    hs_a       = !bus.hsync & hs_q;
    vs_a       = !bus.vsync & vs_q;
    de_r       = bus.de & !de_q;
    first_row  = vs_seen | vs_a;
    h_len      = h_cnt + 12'd1;
    line_bad   = hs_a & ((h_len != HT) | ((a_cnt != 12'd0) & (a_cnt != HA)));
    // a line closing in the same cycle as the frame belongs to that frame
    ln_eff     = ln_cnt + {11'd0, hs_a};
    frame_good = (ln_eff == VT) & (act_ln == VA) & !bad_seen & !line_bad;
    time_out   = !hs_a & (h_cnt == TO);
  end
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hs_q            <= 1'b1;
      vs_q            <= 1'b1;
      de_q            <= 1'b0;
      vs_seen         <= 1'b0;
      bad_seen        <= 1'b0;
      h_cnt           <= '0;
      a_cnt           <= '0;
      ln_cnt          <= '0;
      act_ln          <= '0;
      bus.sx          <= '0;
      bus.sy          <= '0;
      bus.pix_valid   <= 1'b0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.h_total     <= '0;
      bus.v_total     <= '0;
    end else begin
      hs_q            <= bus.hsync;
      vs_q            <= bus.vsync;
      de_q            <= bus.de;
      bus.pix_valid   <= bus.de;
      bus.line_start  <= de_r;
      bus.frame_start <= de_r & first_row;
      vs_seen         <= de_r ? 1'b0 : first_row;
      bus.sx          <= de_r ? 10'd0 : bus.de ? bus.sx + 10'd1 : bus.sx;
      bus.sy          <= !de_r ? bus.sy : first_row ? 10'd0 : bus.sy + 10'd1;
      h_cnt           <= hs_a ? 12'd0 : (&h_cnt) ? h_cnt : h_len;
      a_cnt           <= (hs_a ? 12'd0 : a_cnt) + {11'd0, bus.de};
      if (hs_a) bus.h_total <= h_len;
      if (vs_a) begin
        bus.v_total <= ln_eff;
        ln_cnt      <= '0;
        act_ln      <= '0;
        bad_seen    <= 1'b0;
      end else begin
        ln_cnt      <= ln_eff;
        act_ln      <= act_ln + {11'd0, de_r};
        bad_seen    <= bad_seen | line_bad;
      end
    end
  end
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state          <= SEARCH;
      good_cnt       <= '0;
      bus.locked     <= 1'b0;
      bus.err_timing <= 1'b0;
    end else begin
      bus.err_timing <= 1'b0;
      if (time_out) begin
        bus.err_timing <= 1'b1;
        bus.locked     <= 1'b0;
        state          <= SEARCH;
        good_cnt       <= '0;
      end else begin
        case (state)
          SEARCH: if (vs_a) begin
            state    <= TRACK;
            good_cnt <= '0;
          end
          TRACK: if (vs_a) begin
            if (!frame_good) begin
              good_cnt       <= '0;
              bus.err_timing <= 1'b1;
            end else if (good_cnt + 4'd1 == LF) begin
              good_cnt   <= '0;
              state      <= LOCKED;
              bus.locked <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end
          LOCKED: if (line_bad | (vs_a & !frame_good)) begin
            bus.err_timing <= 1'b1;
            bus.locked     <= 1'b0;
            state          <= TRACK;
            good_cnt       <= '0;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder_480p.sv
// tb_vga_sync_decoder_480p: scoreboard bench on a scaled-down raster (40x20 total, 24x12 active)
module tb_vga_sync_decoder_480p;
  localparam int H_T = 40, H_A = 24, V_T = 20, V_A = 12, TMO = 100;
  localparam int K_FS = 0, K_ERR = 1, K_LOCK = 2;
  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    bit chk;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_sync_decoder_480p_if vif ();
  vga_sync_decoder_480p #(
    .H_TOTAL(H_T), .H_ACTIVE(H_A), .V_TOTAL(V_T), .V_ACTIVE(V_A),
    .LOCK_FRAMES(2), .TIMEOUT(TMO)
  ) dut (
    .clk_vga(clk),
    .rst_n  (rst_n),
    .bus    (vif)
  );
  always #5 clk = ~clk;
  ev_t q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input int kind, input int a, input int b, input int c, input bit ck);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c; e.chk = ck;
    q.push_back(e);
  endtask
  task automatic drive_line(input int vc, input int extra);
    for (int hc = 0; hc < H_T + extra; hc++) begin
      @(negedge clk);
      vif.hsync = !(hc >= H_A + 4 && hc < H_A + 8);
      vif.vsync = !(vc >= V_A + 2 && vc < V_A + 4);
      vif.de    = hc < H_A && vc < V_A;
    end
  endtask
  task automatic frame(input int v0, input int v1, input int stretch);
    for (int vc = v0; vc < v1; vc++) drive_line(vc, vc == stretch ? 1 : 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vif.hsync = 1'b1;
      vif.vsync = 1'b1;
      vif.de    = 1'b0;
    end
  endtask
  task automatic chk_reset_outputs();
    chk("rst_sx", int'(vif.sx), 0);
    chk("rst_sy", int'(vif.sy), 0);
    chk("rst_pix_valid", int'(vif.pix_valid), 0);
    chk("rst_line_start", int'(vif.line_start), 0);
    chk("rst_frame_start", int'(vif.frame_start), 0);
    chk("rst_locked", int'(vif.locked), 0);
    chk("rst_h_total", int'(vif.h_total), 0);
    chk("rst_v_total", int'(vif.v_total), 0);
    chk("rst_err_timing", int'(vif.err_timing), 0);
  endtask
  // monitor: pops one expected event per DUT event and checks its fields
  int  ls_cnt = 0, last_sx = 0, last_sy = 0;
  logic prev_locked = 1'b0;
  task automatic take(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: 0};
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      e  = q.pop_front();
      ok = 1'b1;
      chk("event_kind", kind, e.kind);
    end
  endtask
  initial forever begin
    ev_t e;
    bit ok;
    @(negedge clk);
    if (rst_n) begin
      if (vif.frame_start) begin
        take(K_FS, e, ok);
        if (ok) begin
          chk("fs_sx", int'(vif.sx), 0);
          chk("fs_sy", int'(vif.sy), 0);
          if (e.chk) begin
            chk("line_starts_per_frame", ls_cnt, e.a);
            chk("last_sx", last_sx, e.b);
            chk("last_sy", last_sy, e.c);
          end
        end
        ls_cnt = 0;
      end
      if (vif.err_timing) begin
        take(K_ERR, e, ok);
        if (ok) begin
          chk("err_h_total", int'(vif.h_total), e.a);
          chk("err_v_total", int'(vif.v_total), e.b);
          chk("err_locked", int'(vif.locked), 0);
        end
      end
      if (vif.locked && !prev_locked) begin
        take(K_LOCK, e, ok);
        if (ok) begin
          chk("lock_h_total", int'(vif.h_total), e.a);
          chk("lock_v_total", int'(vif.v_total), e.b);
        end
      end
      if (vif.line_start) ls_cnt++;
      if (vif.pix_valid) begin
        last_sx = int'(vif.sx);
        last_sy = int'(vif.sy);
      end
    end
    prev_locked = vif.locked;
  end
  initial begin
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.de    = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    // start mid-frame: lock expected at the third vsync
    frame(8, V_T, -1);
    push(K_FS, 0, 0, 0, 1'b0);
    frame(0, V_T, -1);
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    push(K_LOCK, H_T, V_T, 0, 1'b0);
    frame(0, V_T, -1);
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    frame(0, V_T, -1);
    // one line stretched by a clock while locked
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    push(K_ERR, H_T + 1, V_T, 0, 1'b0);
    push(K_ERR, H_T, V_T, 0, 1'b0);
    frame(0, V_T, 5);
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    frame(0, V_T, -1);
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    push(K_LOCK, H_T, V_T, 0, 1'b0);
    frame(0, V_T, -1);
    // hsync lost mid-frame, then stream resumes where it stopped
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    push(K_ERR, H_T, V_T, 0, 1'b0);
    frame(0, 10, -1);
    idle(TMO + 50);
    frame(10, V_T, -1);
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    frame(0, V_T, -1);
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    push(K_LOCK, H_T, V_T, 0, 1'b0);
    frame(0, V_T, -1);
    // asynchronous reset in the middle of an active line
    push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
    frame(0, 3, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vif.hsync = 1'b1;
      vif.vsync = 1'b1;
      vif.de    = 1'b1;
    end
    @(posedge clk);
    #2 chk("pre_rst_pix_valid", int'(vif.pix_valid), 1);
    chk("pre_rst_locked", int'(vif.locked), 1);
    rst_n = 1'b0;
    #1 chk_reset_outputs();
    idle(3);
    rst_n = 1'b1;
    // one line short per frame: never locks, error at every vsync once tracking
    frame(0, V_T - 1, -1);
    push(K_FS, 0, 0, 0, 1'b0);
    push(K_ERR, H_T, V_T - 1, 0, 1'b0);
    frame(0, V_T - 1, -1);
    for (int k = 0; k < 2; k++) begin
      push(K_FS, V_A, H_A - 1, V_A - 1, 1'b1);
      push(K_ERR, H_T, V_T - 1, 0, 1'b0);
      frame(0, V_T - 1, -1);
    end
    idle(20);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
